// File: rtl/li_expander_pkg.sv
// Shared constants and types for the load-immediate expander.
package li_expander_pkg;

  localparam logic [5:0] LuiOpDefault = 6'b001111;
  localparam logic [5:0] OriOpDefault = 6'b001101;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StEmit1,
    StEmit2
  } state_e;

  function automatic logic [31:0] encode_itype(input logic [5:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [15:0] imm);
    logic [31:0] word;
    word = '0;
    word[OpcodeMsb:OpcodeLsb] = op;
    word[RsMsb:RsLsb]         = rs;
    word[RtMsb:RtLsb]         = rt;
    word[ImmMsb:ImmLsb]       = imm;
    return word;
  endfunction

endpackage

// File: rtl/li_expander_word_gen.sv
// Combinational encoder: picks ori / lui / lui+ori for a constant and builds
// the word for the requested stage (0 = first word, 1 = trailing ori).
module li_word_gen
  import li_expander_pkg::*;
#(
  parameter logic [5:0] LuiOp = LuiOpDefault,
  parameter logic [5:0] OriOp = OriOpDefault
) (
  input  logic [31:0] value,
  input  logic [4:0]  rt,
  input  logic        stage,
  output logic [31:0] word,
  output logic        last,
  output logic        two_word
);

  logic [15:0] hi;
  logic [15:0] lo;

  assign hi       = value[31:16];
  assign lo       = value[15:0];
  assign two_word = (hi != 16'h0) && (lo != 16'h0);

  always_comb begin
    word = '0;
    last = 1'b1;
    if (stage) begin
      word = encode_itype(OriOp, rt, rt, lo);
      last = 1'b1;
    end else if (hi == 16'h0) begin
      word = encode_itype(OriOp, 5'd0, rt, lo);
      last = 1'b1;
    end else begin
      word = encode_itype(LuiOp, 5'd0, rt, hi);
      last = !two_word;
    end
  end

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: accepts a constant and rt, streams the one or two
// MIPS words that materialise it over a valid/ready output.
module li_expander
  import li_expander_pkg::*;
#(
  parameter logic [5:0] LUI_OP = LuiOpDefault,
  parameter logic [5:0] ORI_OP = OriOpDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  state_e      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [4:0]  rt_q, rt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;

  logic [31:0] gen_value;
  logic [4:0]  gen_rt;
  logic        gen_stage;
  logic [31:0] gen_word;
  logic        gen_last;
  logic        gen_two_word;

  // In IDLE the encoder looks at the live request so the first word can be
  // registered on the accepting edge; afterwards it works from the latch.
  assign gen_value = (state_q == StIdle) ? in_value : value_q;
  assign gen_rt    = (state_q == StIdle) ? in_rt    : rt_q;
  assign gen_stage = (state_q != StIdle);

  li_word_gen #(
    .LuiOp (LUI_OP),
    .OriOp (ORI_OP)
  ) u_word_gen (
    .value    (gen_value),
    .rt       (gen_rt),
    .stage    (gen_stage),
    .word     (gen_word),
    .last     (gen_last),
    .two_word (gen_two_word)
  );

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    rt_d        = rt_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          value_d     = in_value;
          rt_d        = in_rt;
          out_valid_d = 1'b1;
          out_instr_d = gen_word;
          out_last_d  = gen_last;
          state_d     = StEmit1;
        end
      end
      StEmit1: begin
        if (out_ready) begin
          if (gen_two_word) begin
            out_instr_d = gen_word;
            out_last_d  = gen_last;
            state_d     = StEmit2;
          end else begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      StEmit2: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      value_q     <= '0;
      rt_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      rt_q        <= rt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_li_expander.sv
// Bench for li_expander: directed table, backpressure/reset sequences and
// randomized requests checked against a word-list model.
module tb_li_expander;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  li_expander dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_rt     (in_rt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last)
  );

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rt;
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the instruction list for a constant, built from the hi/lo rules.
  task automatic model(input logic [31:0] v, input logic [4:0] r,
                       output int cnt, output logic [31:0] w0, output logic [31:0] w1);
    logic [15:0] hi, lo;
    logic [31:0] lui_w, ori0_w, orir_w;
    hi     = v[31:16];
    lo     = v[15:0];
    lui_w  = (32'd15 << 26) | (32'(r) << 16) | 32'(hi);
    ori0_w = (32'd13 << 26) | (32'(r) << 16) | 32'(lo);
    orir_w = (32'd13 << 26) | (32'(r) << 21) | (32'(r) << 16) | 32'(lo);
    w1 = 32'h0;
    if (hi == 0) begin
      cnt = 1; w0 = ori0_w;
    end else if (lo == 0) begin
      cnt = 1; w0 = lui_w;
    end else begin
      cnt = 2; w0 = lui_w; w1 = orir_w;
    end
  endtask

  task automatic send(input logic [31:0] v, input logic [4:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = v;
    in_rt    = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Consumes cnt words, stalling each for 'stall' cycles; optionally drives
  // a competing request that must be ignored while busy.
  task automatic drain(input int cnt, input logic [31:0] w0, input logic [31:0] w1,
                       input int stall, input bit noise, input string tag);
    logic [31:0] w;
    for (int i = 0; i < cnt; i++) begin
      w = (i == 0) ? w0 : w1;
      @(negedge clk);
      if (noise) begin
        in_valid = 1'b1;
        in_value = 32'h0000_0042;
        in_rt    = 5'd3;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_instr"}, out_instr, w);
      check({tag, "_last"}, 32'(out_last), 32'(i == cnt - 1));
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_w"}, out_instr, w);
        check({tag, "_hold_l"}, 32'(out_last), 32'(i == cnt - 1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    int          cnt;
    logic [31:0] w0, w1, v;
    logic [4:0]  r;

    vecs[0] = '{32'h0000_1234, 5'd8,  1, 32'h3408_1234, 32'h0};
    vecs[1] = '{32'h1234_0000, 5'd9,  1, 32'h3C09_1234, 32'h0};
    vecs[2] = '{32'hDEAD_BEEF, 5'd10, 2, 32'h3C0A_DEAD, 32'h354A_BEEF};
    vecs[3] = '{32'h0000_0000, 5'd2,  1, 32'h3402_0000, 32'h0};
    vecs[4] = '{32'hFFFF_FFFF, 5'd0,  2, 32'h3C00_FFFF, 32'h3400_FFFF};
    vecs[5] = '{32'h0001_0001, 5'd31, 2, 32'h3C1F_0001, 32'h37FF_0001};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    in_rt     = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_last", 32'(out_last), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      send(vecs[i].value, vecs[i].rt);
      drain(vecs[i].cnt, vecs[i].w0, vecs[i].w1, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure on both words with a competing request during emission.
    send(32'hDEAD_BEEF, 5'd10);
    drain(2, 32'h3C0A_DEAD, 32'h354A_BEEF, 5, 1'b1, "bp");

    // Reset between the lui and the ori of a pair.
    send(32'hDEAD_BEEF, 5'd10);
    @(negedge clk);
    check("mid_lui", out_instr, 32'h3C0A_DEAD);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid_no_ori", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Randomized requests against the model.
    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v[31:16] = 16'h0;
        1: v[15:0]  = 16'h0;
        2: v = (i % 2 == 0) ? 32'h0 : v;
        default: ;
      endcase
      r = 5'($urandom);
      model(v, r, cnt, w0, w1);
      send(v, r);
      drain(cnt, w0, w1, int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/li_expander.md
# li_expander

Sequential load-immediate expander. Converts a 32-bit constant and a destination register number into the one or two MIPS I-type instruction words that materialise it: `ori`, `lui`, or the pair `lui`+`ori`. It is the encode-side counterpart of the datapath's 16→32 immediate extension. It sits between the test-program/boot loader and instruction memory, and streams instruction words out over a valid/ready handshake.

## Interface
- `LUI_OP`, default 6'b001111: opcode field for `lui`.
- `ORI_OP`, default 6'b001101: opcode field for `ori`.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: `in_value` and `in_rt` are valid.
- `in_ready` out 1: the block accepts a request this cycle.
- `in_value` in 32: constant to materialise.
- `in_rt` in 5: destination register number.
- `out_valid` out 1: `out_instr` holds a valid word.
- `out_ready` in 1: the consumer accepts the word.
- `out_instr` out 32: encoded instruction word.
- `out_last` out 1: this word is the final word for the current request.

## Operation
- States: `IDLE`, `EMIT1`, `EMIT2`.
- `in_ready` = (state == `IDLE`), decoded combinationally from state. Requests are never accepted outside `IDLE`.
- An input handshake occurs when `in_valid && in_ready`. On it, the block latches `in_value` and `in_rt`, classifies the value, and moves to `EMIT1`.
- Classification, with hi = `in_value[31:16]` and lo = `in_value[15:0]`:
  - If hi == 0: emit a single word, `ori rt,$0,lo` = {`ORI_OP`, 5'd0, rt, lo}, with `out_last`=1. This covers value 0.
  - Else if lo == 0: emit a single word, `lui rt,hi` = {`LUI_OP`, 5'd0, rt, hi}, with `out_last`=1.
  - Otherwise emit two words. First `lui rt,hi` with `out_last`=0. Then `ori rt,rt,lo` = {`ORI_OP`, rt, rt, lo} with `out_last`=1.
- `EMIT1` with `out_ready`:
  - Single-word request: go to `IDLE`.
  - Two-word request: go to `EMIT2` and load the `ori` word.
- `EMIT2` with `out_ready`: go to `IDLE`.
- `in_rt` = 0 is encoded normally, with no special case.
- No sign extension is applied anywhere. The `ori` immediate is zero-extended by the executing datapath.

## Timing
- Outputs are registered.
- Input accepted at edge N: `out_valid`=1 with the first word visible after edge N.
- A word is consumed at the edge where `out_valid && out_ready`.
  - For a two-word request, the second word is visible the cycle after the first is consumed.
  - After the last word is consumed, `out_valid`=0 and `in_ready`=1 in the next cycle.
- Throughput is at most one request per 2 cycles (single word) or 3 cycles (pair).
- Backpressure: while `out_valid && !out_ready`, `out_instr`, `out_last` and `out_valid` hold stable for any number of cycles.
- `in_valid` and `in_value` are ignored outside `IDLE`.
- Reset values: state = `IDLE`, `out_valid`=0, `out_instr`=32'h0, `out_last`=0, latched value and rt = 0. `in_ready` is therefore 1 during and after reset.
- Reset asserted mid-request, including between the two words of a pair: the pending word(s) are dropped. No partial pair is emitted after reset deasserts.

## Structure
- Shared package holds:
  - `LUI_OP` and `ORI_OP` opcode constants.
  - Field-position constants (opcode [31:26], rs [25:21], rt [20:16], imm [15:0]).
  - The state enum.
- One combinational sub-module, `li_word_gen`: takes the value, rt and a stage bit; outputs the encoded word, a `last` flag and a `two_word` flag.
- The top level holds the FSM and output registers.

## Test plan
- Upper-half-zero value: value 32'h0000_1234, rt=8 → one word 32'h3408_1234 with `out_last`=1; `in_ready` returns the cycle after consumption.
- Lower-half-zero value: value 32'h1234_0000, rt=9 → one word 32'h3C09_1234 with `out_last`=1.
- Full 32-bit value: value 32'hDEAD_BEEF, rt=10 → 32'h3C0A_DEAD (`out_last`=0), then 32'h354A_BEEF (`out_last`=1) on consecutive consumed cycles.
- Zero: value 0, rt=2 → single word 32'h3402_0000.
- Backpressure and ignored input: value 32'hDEAD_BEEF, rt=10 with `out_ready` low for 5 cycles on each word → words held stable, no duplicates or drops. A second `in_valid` during emission is ignored until `IDLE`.
- Reset mid-pair: `reset` pulsed after the `lui` word is consumed → `out_valid`=0 immediately, `in_ready`=1, and no `ori` word ever appears.
